// File: rtl/instr_sequencer.sv
// Program sequencer for the Simple RISC Machine: fetches instructions from a
// synchronous-read memory and hands them to the cpu one at a time.
module instr_sequencer #(
    parameter int ADDR_W = 8,
    parameter int WDOG   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   prog_len,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       cpu_in,
    output logic              cpu_load,
    output logic              cpu_s,
    input  logic              cpu_w,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   pc
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_CAPT  = 3'd2;
    localparam logic [2:0] S_LOAD  = 3'd3;
    localparam logic [2:0] S_START = 3'd4;
    localparam logic [2:0] S_ACK   = 3'd5;
    localparam logic [2:0] S_EXEC  = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    localparam int            WDW    = $clog2(WDOG + 1);
    localparam logic [WDW-1:0] WD_LIM = WDW'(WDOG - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [WDW-1:0]    r_wdog;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_pc;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [15:0]       r_cpu_in;
    logic              r_mem_rd;
    logic              r_cpu_load;
    logic              r_cpu_s;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              w_abort;
    logic              w_last;
    logic              w_wait_st;
    logic [ADDR_W:0]   w_pc_inc;

    assign w_pc_inc  = r_pc + (ADDR_W + 1)'(1);
    assign w_last    = (w_pc_inc == r_len);
    assign w_wait_st = (r_state == S_LOAD) || (r_state == S_ACK) || (r_state == S_EXEC);

    // The awaited cpu_w condition is tested before the limit, so a
    // transition landing on the limit cycle is not an abort.
    always_comb begin
        w_next  = r_state;
        w_abort = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_next = (prog_len == '0) ? S_DONE : S_FETCH;
            S_FETCH:        w_next = S_CAPT;
            S_CAPT:         w_next = S_LOAD;
            S_LOAD:         if (cpu_w) w_next = S_START;
                            else if (r_wdog == WD_LIM) w_abort = 1'b1;
            S_START:        w_next = S_ACK;
            S_ACK:          if (!cpu_w) w_next = S_EXEC;
                            else if (r_wdog == WD_LIM) w_abort = 1'b1;
            S_EXEC:         if (cpu_w) w_next = w_last ? S_DONE : S_FETCH;
                            else if (r_wdog == WD_LIM) w_abort = 1'b1;
            default:        w_next = S_IDLE;
        endcase
        if (w_abort) w_next = S_DONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_wdog     <= '0;
            r_len      <= '0;
            r_pc       <= '0;
            r_mem_addr <= '0;
            r_cpu_in   <= '0;
            r_mem_rd   <= 1'b0;
            r_cpu_load <= 1'b0;
            r_cpu_s    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_wdog <= '0;
            else if (w_wait_st)
                r_wdog <= r_wdog + WDW'(1);

            r_mem_rd   <= (w_next == S_FETCH);
            r_cpu_load <= (r_state == S_LOAD) && (w_next == S_START);
            r_cpu_s    <= (r_state == S_START);
            r_busy     <= (w_next != S_IDLE) && (w_next != S_DONE);
            r_done     <= (w_next == S_DONE);

            case (r_state)
                S_IDLE, S_DONE: if (start) begin
                    r_len      <= prog_len;
                    r_pc       <= '0;
                    r_mem_addr <= '0;
                    r_err      <= 1'b0;
                end
                S_CAPT: r_cpu_in <= mem_rdata;
                S_EXEC: if (cpu_w) begin
                    r_pc <= w_pc_inc;
                    // Address only advances when another fetch follows, so a
                    // full-size program never wraps back onto address 0.
                    if (!w_last) r_mem_addr <= r_mem_addr + ADDR_W'(1);
                end
                default: ;
            endcase
            if (w_abort) r_err <= 1'b1;
        end
    end

    assign mem_addr = r_mem_addr;
    assign mem_rd   = r_mem_rd;
    assign cpu_in   = r_cpu_in;
    assign cpu_load = r_cpu_load;
    assign cpu_s    = r_cpu_s;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign pc       = r_pc;

endmodule
